// File: rtl/lcd_st_channel_adapter.sv
`default_nettype none
// =============================================================================
// lcd_st_channel_adapter : packet-granular channel filter and remapper with a
//                          two-entry skid-buffered Avalon-ST output
// Revision 1.0
// =============================================================================
module lcd_st_channel_adapter #(
    parameter int DATA_W         = 8,
    parameter int IN_CHANNEL_W   = 8,
    parameter int OUT_CHANNEL_W  = 2,
    parameter int CHANNEL_OFFSET = 0,
    parameter int MAX_CHANNEL    = 3,
    parameter int DROP_CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    output logic                     in_ready,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [IN_CHANNEL_W-1:0]  in_channel,
    input  logic                     in_startofpacket,
    input  logic                     in_endofpacket,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [OUT_CHANNEL_W-1:0] out_channel,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket,
    input  logic                     drop_clear,
    output logic [DROP_CNT_W-1:0]    drop_count,
    output logic                     proto_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } state_t;

    localparam logic [IN_CHANNEL_W:0]   OFFSET_EXT = (IN_CHANNEL_W+1)'(CHANNEL_OFFSET);
    localparam logic [IN_CHANNEL_W:0]   MAX_EXT    = (IN_CHANNEL_W+1)'(MAX_CHANNEL);
    localparam logic [DROP_CNT_W-1:0]   CNT_ONE    = {{(DROP_CNT_W-1){1'b0}}, 1'b1};

    state_t                   state_q, state_d;
    logic [IN_CHANNEL_W-1:0]  sop_ch_q, sop_ch_d;
    logic [OUT_CHANNEL_W-1:0] map_ch_q, map_ch_d;
    logic                     out_valid_q, out_valid_d;
    logic [DATA_W-1:0]        out_data_q, out_data_d;
    logic [OUT_CHANNEL_W-1:0] out_ch_q, out_ch_d;
    logic                     out_sop_q, out_sop_d;
    logic                     out_eop_q, out_eop_d;
    logic                     skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0]        skid_data_q, skid_data_d;
    logic [OUT_CHANNEL_W-1:0] skid_ch_q, skid_ch_d;
    logic                     skid_sop_q, skid_sop_d;
    logic                     skid_eop_q, skid_eop_d;
    logic                     in_ready_q, in_ready_d;
    logic [DROP_CNT_W-1:0]    drop_count_q, drop_count_d;
    logic                     proto_err_q, proto_err_d;

    logic                     accept, legal, fwd, disc, pop;
    logic [IN_CHANNEL_W:0]    ext_ch, rel_ch;
    logic [OUT_CHANNEL_W-1:0] beat_ch;

    always_comb begin
        state_d      = state_q;
        sop_ch_d     = sop_ch_q;
        map_ch_d     = map_ch_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_ch_d     = out_ch_q;
        out_sop_d    = out_sop_q;
        out_eop_d    = out_eop_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_ch_d    = skid_ch_q;
        skid_sop_d   = skid_sop_q;
        skid_eop_d   = skid_eop_q;
        drop_count_d = drop_count_q;
        proto_err_d  = 1'b0;
        fwd          = 1'b0;
        disc         = 1'b0;
        beat_ch      = map_ch_q;

        accept = in_valid && in_ready_q;
        pop    = out_valid_q && out_ready;
        ext_ch = {1'b0, in_channel};
        rel_ch = ext_ch - OFFSET_EXT;
        legal  = (ext_ch >= OFFSET_EXT) && (rel_ch <= MAX_EXT);

        // An SOP always restarts packet evaluation, whatever state it arrives in.
        if (accept) begin
            if (in_startofpacket) begin
                proto_err_d = (state_q != IDLE);
                if (legal) begin
                    fwd      = 1'b1;
                    beat_ch  = rel_ch[OUT_CHANNEL_W-1:0];
                    map_ch_d = rel_ch[OUT_CHANNEL_W-1:0];
                    sop_ch_d = in_channel;
                    state_d  = in_endofpacket ? IDLE : PASS;
                end else begin
                    disc    = 1'b1;
                    state_d = in_endofpacket ? IDLE : DROP;
                end
            end else begin
                case (state_q)
                    PASS: begin
                        fwd         = 1'b1;
                        proto_err_d = (in_channel != sop_ch_q);
                        if (in_endofpacket) state_d = IDLE;
                    end
                    DROP: begin
                        disc = 1'b1;
                        if (in_endofpacket) state_d = IDLE;
                    end
                    default: begin
                        disc        = 1'b1;
                        proto_err_d = 1'b1;
                    end
                endcase
            end
        end

        // A push can never meet an occupied skid: in_ready is low whenever it is.
        if (!out_valid_q || pop) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_ch_d     = skid_ch_q;
                out_sop_d    = skid_sop_q;
                out_eop_d    = skid_eop_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = fwd;
                if (fwd) begin
                    out_data_d = in_data;
                    out_ch_d   = beat_ch;
                    out_sop_d  = in_startofpacket;
                    out_eop_d  = in_endofpacket;
                end
            end
        end else if (fwd) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
            skid_ch_d    = beat_ch;
            skid_sop_d   = in_startofpacket;
            skid_eop_d   = in_endofpacket;
        end
        in_ready_d = !skid_valid_d;

        if (drop_clear) begin
            drop_count_d = disc ? CNT_ONE : '0;
        end else if (disc && (drop_count_q != '1)) begin
            drop_count_d = drop_count_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            sop_ch_q     <= '0;
            map_ch_q     <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_ch_q     <= '0;
            out_sop_q    <= 1'b0;
            out_eop_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_ch_q    <= '0;
            skid_sop_q   <= 1'b0;
            skid_eop_q   <= 1'b0;
            in_ready_q   <= 1'b0;
            drop_count_q <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sop_ch_q     <= sop_ch_d;
            map_ch_q     <= map_ch_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_ch_q     <= out_ch_d;
            out_sop_q    <= out_sop_d;
            out_eop_q    <= out_eop_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_ch_q    <= skid_ch_d;
            skid_sop_q   <= skid_sop_d;
            skid_eop_q   <= skid_eop_d;
            in_ready_q   <= in_ready_d;
            drop_count_q <= drop_count_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign in_ready          = in_ready_q;
    assign out_valid         = out_valid_q;
    assign out_data          = out_data_q;
    assign out_channel       = out_ch_q;
    assign out_startofpacket = out_sop_q;
    assign out_endofpacket   = out_eop_q;
    assign drop_count        = drop_count_q;
    assign proto_err         = proto_err_q;

endmodule
`default_nettype wire
